// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the I/D-cache to L2 arbiter.
package cache_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        LAST_I = 1'b0,
        LAST_D = 1'b1
    } last_grant_e;

endpackage

// File: rtl/cache_arbiter.sv
// Two-master Wishbone arbiter: I-cache and D-cache share one L2 port.
// Round-robin on contention, one idle cycle between grants.
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              icache_arbiter_cyc,
    input  logic              icache_arbiter_stb,
    input  logic              icache_arbiter_we,
    input  logic [SEL_W-1:0]  icache_arbiter_sel,
    input  logic [ADDR_W-1:0] icache_arbiter_adr,
    input  logic [DATA_W-1:0] icache_arbiter_dat_m,
    output logic [DATA_W-1:0] icache_arbiter_dat_s,
    output logic              icache_arbiter_ack,
    output logic              icache_arbiter_rty,

    input  logic              dcache_arbiter_cyc,
    input  logic              dcache_arbiter_stb,
    input  logic              dcache_arbiter_we,
    input  logic [SEL_W-1:0]  dcache_arbiter_sel,
    input  logic [ADDR_W-1:0] dcache_arbiter_adr,
    input  logic [DATA_W-1:0] dcache_arbiter_dat_m,
    output logic [DATA_W-1:0] dcache_arbiter_dat_s,
    output logic              dcache_arbiter_ack,
    output logic              dcache_arbiter_rty,

    output logic              arbiter_l2cache_cyc,
    output logic              arbiter_l2cache_stb,
    output logic              arbiter_l2cache_we,
    output logic [SEL_W-1:0]  arbiter_l2cache_sel,
    output logic [ADDR_W-1:0] arbiter_l2cache_adr,
    output logic [DATA_W-1:0] arbiter_l2cache_dat_m,
    input  logic [DATA_W-1:0] arbiter_l2cache_dat_s,
    input  logic              arbiter_l2cache_ack,
    input  logic              arbiter_l2cache_rty
);

    arb_state_e  state;
    last_grant_e last;
    logic        req_i;
    logic        req_d;
    logic        done;

    assign req_i = icache_arbiter_cyc & icache_arbiter_stb;
    assign req_d = dcache_arbiter_cyc & dcache_arbiter_stb;
    assign done  = arbiter_l2cache_ack | arbiter_l2cache_rty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= LAST_I;
        end else begin
            unique case (state)
                IDLE: begin
                    // D wins a tie unless it was the last one served
                    if (req_d && (!req_i || last == LAST_I))
                        state <= GRANT_D;
                    else if (req_i)
                        state <= GRANT_I;
                end
                GRANT_I: begin
                    if (done) begin
                        state <= IDLE;
                        last  <= LAST_I;
                    end else if (!icache_arbiter_cyc) begin
                        state <= IDLE;
                    end
                end
                GRANT_D: begin
                    if (done) begin
                        state <= IDLE;
                        last  <= LAST_D;
                    end else if (!dcache_arbiter_cyc) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign icache_arbiter_dat_s = arbiter_l2cache_dat_s;
    assign dcache_arbiter_dat_s = arbiter_l2cache_dat_s;

    always_comb begin
        arbiter_l2cache_cyc   = 1'b0;
        arbiter_l2cache_stb   = 1'b0;
        arbiter_l2cache_we    = 1'b0;
        arbiter_l2cache_sel   = '0;
        arbiter_l2cache_adr   = '0;
        arbiter_l2cache_dat_m = '0;
        icache_arbiter_ack    = 1'b0;
        icache_arbiter_rty    = 1'b0;
        dcache_arbiter_ack    = 1'b0;
        dcache_arbiter_rty    = 1'b0;
        unique case (state)
            GRANT_I: begin
                arbiter_l2cache_cyc   = icache_arbiter_cyc;
                arbiter_l2cache_stb   = icache_arbiter_stb;
                arbiter_l2cache_we    = icache_arbiter_we;
                arbiter_l2cache_sel   = icache_arbiter_sel;
                arbiter_l2cache_adr   = icache_arbiter_adr;
                arbiter_l2cache_dat_m = icache_arbiter_dat_m;
                icache_arbiter_ack    = arbiter_l2cache_ack;
                icache_arbiter_rty    = arbiter_l2cache_rty;
            end
            GRANT_D: begin
                arbiter_l2cache_cyc   = dcache_arbiter_cyc;
                arbiter_l2cache_stb   = dcache_arbiter_stb;
                arbiter_l2cache_we    = dcache_arbiter_we;
                arbiter_l2cache_sel   = dcache_arbiter_sel;
                arbiter_l2cache_adr   = dcache_arbiter_adr;
                arbiter_l2cache_dat_m = dcache_arbiter_dat_m;
                dcache_arbiter_ack    = arbiter_l2cache_ack;
                dcache_arbiter_rty    = arbiter_l2cache_rty;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: grant order, pass-through, abort, reset.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;

    logic         i_cyc, i_stb, i_we;
    logic [15:0]  i_sel;
    logic [27:0]  i_adr;
    logic [127:0] i_datm, i_dats;
    logic         i_ack, i_rty;

    logic         d_cyc, d_stb, d_we;
    logic [15:0]  d_sel;
    logic [27:0]  d_adr;
    logic [127:0] d_datm, d_dats;
    logic         d_ack, d_rty;

    logic         l_cyc, l_stb, l_we;
    logic [15:0]  l_sel;
    logic [27:0]  l_adr;
    logic [127:0] l_datm, l_dats;
    logic         l_ack, l_rty;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [127:0] DBEEF = 128'hDEAD0000_11112222_33334444_0000BEEF;

    always #5 clk = ~clk;

    cache_arbiter dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .icache_arbiter_cyc    (i_cyc),
        .icache_arbiter_stb    (i_stb),
        .icache_arbiter_we     (i_we),
        .icache_arbiter_sel    (i_sel),
        .icache_arbiter_adr    (i_adr),
        .icache_arbiter_dat_m  (i_datm),
        .icache_arbiter_dat_s  (i_dats),
        .icache_arbiter_ack    (i_ack),
        .icache_arbiter_rty    (i_rty),
        .dcache_arbiter_cyc    (d_cyc),
        .dcache_arbiter_stb    (d_stb),
        .dcache_arbiter_we     (d_we),
        .dcache_arbiter_sel    (d_sel),
        .dcache_arbiter_adr    (d_adr),
        .dcache_arbiter_dat_m  (d_datm),
        .dcache_arbiter_dat_s  (d_dats),
        .dcache_arbiter_ack    (d_ack),
        .dcache_arbiter_rty    (d_rty),
        .arbiter_l2cache_cyc   (l_cyc),
        .arbiter_l2cache_stb   (l_stb),
        .arbiter_l2cache_we    (l_we),
        .arbiter_l2cache_sel   (l_sel),
        .arbiter_l2cache_adr   (l_adr),
        .arbiter_l2cache_dat_m (l_datm),
        .arbiter_l2cache_dat_s (l_dats),
        .arbiter_l2cache_ack   (l_ack),
        .arbiter_l2cache_rty   (l_rty)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ireq(input logic on, input logic [27:0] a);
        i_cyc = on; i_stb = on; i_we = 1'b0; i_adr = a;
        i_sel = 16'h00FF; i_datm = 128'h1;
    endtask

    task automatic dreq(input logic on, input logic [27:0] a);
        d_cyc = on; d_stb = on; d_we = on; d_adr = a;
        d_sel = 16'hFFFF; d_datm = 128'h5A5A;
    endtask

    initial begin
        rst_n = 1'b0;
        ireq(1'b0, 28'h0);
        dreq(1'b0, 28'h0);
        l_dats = '0; l_ack = 1'b0; l_rty = 1'b0;

        // reset holds every output low even with requests and L2 ack
        #3;
        ireq(1'b1, 28'h77);
        l_ack = 1'b1;
        #1;
        chk("rst_l2cyc", 128'(l_cyc), 128'(0));
        chk("rst_iack", 128'(i_ack), 128'(0));
        chk("rst_dack", 128'(d_ack), 128'(0));
        chk("rst_l2adr", 128'(l_adr), 128'(0));
        #8;
        chk("rst_clk_l2cyc", 128'(l_cyc), 128'(0));
        ireq(1'b0, 28'h0);
        l_ack = 1'b0;
        #2 rst_n = 1'b1;

        // icache-only read
        tick();
        ireq(1'b1, 28'h0000040);
        #1;
        chk("t1_idle_cyc", 128'(l_cyc), 128'(0));
        tick();
        chk("t1_cyc", 128'(l_cyc), 128'(1));
        chk("t1_adr", 128'(l_adr), 128'(28'h40));
        chk("t1_we", 128'(l_we), 128'(0));
        chk("t1_sel", 128'(l_sel), 128'(16'h00FF));
        l_ack = 1'b1; l_dats = DBEEF;
        #1;
        chk("t1_iack", 128'(i_ack), 128'(1));
        chk("t1_idats", i_dats, DBEEF);
        chk("t1_dack", 128'(d_ack), 128'(0));
        chk("t1_ddats", d_dats, DBEEF);
        tick();
        l_ack = 1'b0;
        ireq(1'b0, 28'h0);
        #1;
        chk("t1_done_cyc", 128'(l_cyc), 128'(0));

        // simultaneous from reset: dcache first
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        ireq(1'b1, 28'h10);
        dreq(1'b1, 28'h20);
        tick();
        chk("t2_adr_d", 128'(l_adr), 128'(28'h20));
        chk("t2_we_d", 128'(l_we), 128'(1));
        chk("t2_sel_d", 128'(l_sel), 128'(16'hFFFF));
        chk("t2_datm_d", l_datm, 128'h5A5A);
        l_ack = 1'b1;
        #1;
        chk("t2_dack", 128'(d_ack), 128'(1));
        chk("t2_iack_held", 128'(i_ack), 128'(0));
        tick();
        l_ack = 1'b0;
        dreq(1'b0, 28'h0);
        #1;
        chk("t2_gap_cyc", 128'(l_cyc), 128'(0));
        tick();
        chk("t2_cyc_i", 128'(l_cyc), 128'(1));
        chk("t2_adr_i", 128'(l_adr), 128'(28'h10));
        l_ack = 1'b1;
        #1;
        chk("t2_iack", 128'(i_ack), 128'(1));
        tick();
        l_ack = 1'b0;
        ireq(1'b0, 28'h0);

        // continuous contention alternates D,I,D,I
        ireq(1'b1, 28'h100);
        dreq(1'b1, 28'h200);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t3_adr%0d", k), 128'(l_adr),
                128'((k % 2 == 0) ? 28'h200 : 28'h100));
            l_ack = 1'b1;
            tick();
            l_ack = 1'b0;
            #1;
            chk($sformatf("t3_gap%0d", k), 128'(l_cyc), 128'(0));
        end
        ireq(1'b0, 28'h0);
        dreq(1'b0, 28'h0);
        tick();

        // icache abort with dcache pending
        ireq(1'b1, 28'h300);
        tick();
        chk("t4_adr_i", 128'(l_adr), 128'(28'h300));
        dreq(1'b1, 28'h400);
        #1;
        chk("t4_holdoff", 128'(l_adr), 128'(28'h300));
        tick();
        chk("t4_still_i", 128'(l_adr), 128'(28'h300));
        i_cyc = 1'b0;
        #1;
        chk("t4_abort_cyc", 128'(l_cyc), 128'(0));
        tick();
        chk("t4_idle_cyc", 128'(l_cyc), 128'(0));
        tick();
        chk("t4_adr_d", 128'(l_adr), 128'(28'h400));
        chk("t4_cyc_d", 128'(l_cyc), 128'(1));
        l_ack = 1'b1;
        #1;
        chk("t4_dack", 128'(d_ack), 128'(1));
        tick();
        l_ack = 1'b0;
        ireq(1'b0, 28'h0);
        dreq(1'b0, 28'h0);
        tick();

        // dcache abort on CYC drop
        dreq(1'b1, 28'h440);
        tick();
        chk("t4b_cyc_d", 128'(l_cyc), 128'(1));
        d_cyc = 1'b0;
        tick();
        d_cyc = 1'b1;
        l_ack = 1'b1;
        #1;
        chk("t4b_idle_ack", 128'(d_ack), 128'(0));
        chk("t4b_idle_cyc", 128'(l_cyc), 128'(0));
        l_ack = 1'b0;
        dreq(1'b0, 28'h0);
        tick();

        // reset mid dcache transfer
        dreq(1'b1, 28'h500);
        tick();
        chk("t5_cyc_d", 128'(l_cyc), 128'(1));
        rst_n = 1'b0;
        l_ack = 1'b1;
        #1;
        chk("t5_rst_cyc", 128'(l_cyc), 128'(0));
        chk("t5_rst_dack", 128'(d_ack), 128'(0));
        #1;
        rst_n = 1'b1;
        l_ack = 1'b0;
        tick();
        chk("t5_regrant", 128'(l_adr), 128'(28'h500));
        l_ack = 1'b1;
        #1;
        chk("t5_dack", 128'(d_ack), 128'(1));
        tick();
        l_ack = 1'b0;
        dreq(1'b0, 28'h0);

        // retry during GRANT_I
        ireq(1'b1, 28'h600);
        tick();
        l_rty = 1'b1;
        #1;
        chk("t6_irty", 128'(i_rty), 128'(1));
        chk("t6_iack", 128'(i_ack), 128'(0));
        chk("t6_drty", 128'(d_rty), 128'(0));
        tick();
        l_rty = 1'b0;
        ireq(1'b0, 28'h0);
        #1;
        chk("t6_idle_cyc", 128'(l_cyc), 128'(0));

        // stray ack/rty in IDLE is ignored
        l_ack = 1'b1; l_rty = 1'b1;
        #1;
        chk("t7_iack", 128'(i_ack), 128'(0));
        chk("t7_dack", 128'(d_ack), 128'(0));
        chk("t7_irty", 128'(i_rty), 128'(0));
        tick();
        chk("t7_cyc", 128'(l_cyc), 128'(0));
        l_ack = 1'b0; l_rty = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
